memory_responder: RTL and testbench

Memory-side responder for the CPU memory bus (readM/writeM/address/data/ackOutput/inputReady). Accepts one read or write request at a time, waits a programmable latency, then completes the request with a level handshake: inputReady plus driven data for reads, ackOutput for writes. Sits between the cpu and the testbench top level as the single instruction/data memory, built around a word-addressed storage array.

---
 rtl/memory_responder_pkg.sv | 19 +
 rtl/memory_responder_if.sv | 25 ++
 rtl/memory_responder_memory_array.sv | 25 ++
 rtl/memory_responder.sv | 123 ++++++++++++
 tb/tb_memory_responder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: bus word width and the
// controller state encoding.
package memory_responder_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [2:0] {
        MEM_IDLE       = 3'd0,
        MEM_READ_WAIT  = 3'd1,
        MEM_READ_RESP  = 3'd2,
        MEM_WRITE_WAIT = 3'd3,
        MEM_WRITE_ACK  = 3'd4
    } mem_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// CPU memory bus request/response signals, plus the responder's state for observation.
interface memory_responder_if;

    // Level handshake: the master holds readM or writeM (with address) high
    // until the slave raises inputReady (read) or ackOutput (write); the
    // slave holds its response high until it samples the request low.
    logic                                       readM;
    logic                                       writeM;
    logic [memory_responder_pkg::WORD_SIZE-1:0] address;
    logic                                       inputReady;
    logic                                       ackOutput;
    logic                                       protocol_error;
    memory_responder_pkg::mem_state_e           state;

    modport master (
        output readM, writeM, address,
        input  inputReady, ackOutput, protocol_error, state
    );

    modport slave (
        input  readM, writeM, address,
        output inputReady, ackOutput, protocol_error, state
    );

endinterface

// File: rtl/memory_responder_memory_array.sv
// Word-addressed storage: synchronous write, combinational read on a shared
// address. Holds no control state and is not touched by reset.
module memory_array #(
    parameter  int WORD_SIZE  = 16,
    parameter  int ADDR_DEPTH = 256,
    localparam int IDX_W      = $clog2(ADDR_DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [IDX_W-1:0]     i_addr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] o_rdata
);

    logic [WORD_SIZE-1:0] r_mem [ADDR_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: accepts one read or write at a time, waits a fixed
// latency, then answers with a level handshake until the request drops.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_DEPTH    = 256,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_responder_if.slave    bus,
    inout  wire  [WORD_SIZE-1:0] data
);

    localparam int IDX_W   = $clog2(ADDR_DEPTH);
    localparam int MAX_LAT = max_int(READ_LATENCY, WRITE_LATENCY);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    mem_state_e           r_state, w_state;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic [IDX_W-1:0]     r_addr, w_addr;
    logic [WORD_SIZE-1:0] r_wdata, w_wdata;
    logic [WORD_SIZE-1:0] r_rdata, w_rdata;
    logic                 r_perr, w_perr;
    logic                 w_we;
    logic                 w_oe;
    logic [WORD_SIZE-1:0] w_mem_rdata;
    wire                  w_unused_addr = ^bus.address[WORD_SIZE-1:IDX_W];

    memory_array #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_DEPTH (ADDR_DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MEM_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_rdata <= w_rdata;
            r_perr  <= w_perr;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_rdata = r_rdata;
        w_perr  = 1'b0;
        w_we    = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                // A read wins over a simultaneous write; the collision is flagged.
                if (bus.readM) begin
                    w_addr  = bus.address[IDX_W-1:0];
                    w_cnt   = RD_LOAD;
                    w_perr  = bus.writeM;
                    w_state = MEM_READ_WAIT;
                end else if (bus.writeM) begin
                    w_addr  = bus.address[IDX_W-1:0];
                    w_wdata = data;
                    w_cnt   = WR_LOAD;
                    w_state = MEM_WRITE_WAIT;
                end
            end
            MEM_READ_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - 1'b1;
                end else begin
                    w_rdata = w_mem_rdata;
                    w_state = MEM_READ_RESP;
                end
            end
            MEM_READ_RESP: begin
                if (!bus.readM) begin
                    w_state = MEM_IDLE;
                end
            end
            MEM_WRITE_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - 1'b1;
                end else begin
                    w_we    = 1'b1;
                    w_state = MEM_WRITE_ACK;
                end
            end
            MEM_WRITE_ACK: begin
                if (!bus.writeM) begin
                    w_state = MEM_IDLE;
                end
            end
            default: w_state = MEM_IDLE;
        endcase
    end

    // Response outputs and the bus driver enable decode registered state only.
    assign w_oe               = (r_state == MEM_READ_RESP);
    assign bus.inputReady     = w_oe;
    assign bus.ackOutput      = (r_state == MEM_WRITE_ACK);
    assign bus.protocol_error = r_perr;
    assign bus.state          = r_state;
    assign data               = w_oe ? r_rdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: transaction tasks, a reference memory
// model with an expected-read queue, and a per-cycle output compare process.
module tb_memory_responder;
    import memory_responder_pkg::*;

    localparam int RL = 2;
    localparam int WL = 2;
    localparam logic [15:0] RELEASED = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        tb_drv;
    logic [15:0] tb_data;
    wire  [15:0] data;

    memory_responder_if bus ();

    assign data = tb_drv ? tb_data : 16'hzzzz;
    pullup (data);

    memory_responder #(
        .ADDR_DEPTH    (256),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .data  (data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] cur_exp = '0;
    logic        prev_ir = 1'b0;
    logic [15:0] got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Every cycle: bus carries the predicted read word while inputReady is
    // high and is released otherwise; read and write responses never overlap.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.inputReady) begin
                if (!prev_ir) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_read_response at %0t", $time);
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                end
                check("rd_data", 32'(data), 32'(cur_exp));
            end else if (!tb_drv) begin
                check("data_released", 32'(data), 32'(RELEASED));
            end
            check("resp_exclusive", 32'(bus.inputReady & bus.ackOutput), 32'd0);
        end
        prev_ir = bus.inputReady;
    end

    task automatic do_write(input logic [15:0] addr, input logic [15:0] wd, input int hold);
        int lat;
        @(posedge clk); #1;
        bus.writeM  = 1'b1;
        bus.address = addr;
        tb_drv      = 1'b1;
        tb_data     = wd;
        @(posedge clk); #1;
        tb_drv = 1'b0;
        check("wr_accept_state", 32'(bus.state), 32'(MEM_WRITE_WAIT));
        lat = 0;
        while (!bus.ackOutput && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("wr_latency", 32'(lat), 32'(WL));
        exp_mem[addr[7:0]] = wd;
        for (int h = 0; h < hold; h++) begin
            bus.address = addr + 16'(h + 1);
            @(posedge clk); #1;
            check("wr_ack_held", 32'(bus.ackOutput), 32'd1);
        end
        bus.writeM = 1'b0;
        @(posedge clk); #1;
        check("wr_ack_drop", 32'(bus.ackOutput), 32'd0);
        check("wr_idle", 32'(bus.state), 32'(MEM_IDLE));
    endtask

    task automatic do_read(input logic [15:0] addr, input int hold, input logic with_write,
                           output logic [15:0] rd);
        int lat;
        @(posedge clk); #1;
        bus.readM   = 1'b1;
        bus.address = addr;
        exp_q.push_back(exp_mem[addr[7:0]]);
        if (with_write) begin
            bus.writeM = 1'b1;
            tb_drv     = 1'b1;
            tb_data    = 16'hDEAD;
        end
        @(posedge clk); #1;
        tb_drv     = 1'b0;
        bus.writeM = 1'b0;
        check("rd_accept_state", 32'(bus.state), 32'(MEM_READ_WAIT));
        check("perr_after_accept", 32'(bus.protocol_error), 32'(with_write));
        lat = 0;
        while (!bus.inputReady && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check("perr_one_cycle", 32'(bus.protocol_error), 32'd0);
        end
        check("rd_latency", 32'(lat), 32'(RL));
        rd = data;
        for (int h = 0; h < hold; h++) begin
            bus.address = addr + 16'(h + 1);
            @(posedge clk); #1;
            check("rd_ir_held", 32'(bus.inputReady), 32'd1);
            check("rd_no_reaccept", 32'(bus.state), 32'(MEM_READ_RESP));
        end
        bus.readM = 1'b0;
        @(posedge clk); #1;
        check("rd_ir_drop", 32'(bus.inputReady), 32'd0);
        check("rd_data_z", 32'(data), 32'(RELEASED));
        check("rd_idle", 32'(bus.state), 32'(MEM_IDLE));
    endtask

    initial begin
        reset       = 1'b1;
        bus.readM   = 1'b0;
        bus.writeM  = 1'b0;
        bus.address = '0;
        tb_drv      = 1'b0;
        tb_data     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ir", 32'(bus.inputReady), 32'd0);
        check("rst_ack", 32'(bus.ackOutput), 32'd0);
        check("rst_perr", 32'(bus.protocol_error), 32'd0);
        check("rst_state", 32'(bus.state), 32'(MEM_IDLE));
        check("rst_data_z", 32'(data), 32'(RELEASED));
        reset = 1'b0;

        // Basic read with the response dropped immediately.
        do_write(16'd5, 16'h1234, 0);
        do_read(16'd5, 0, 1'b0, got);
        check("lit_read5", 32'(got), 32'h1234);

        // Write with held ack, then read-back.
        do_write(16'd7, 16'hBEEF, 1);
        do_read(16'd7, 0, 1'b0, got);
        check("lit_read7", 32'(got), 32'hBEEF);

        // Simultaneous request: read wins and memory keeps its value.
        do_read(16'd5, 0, 1'b1, got);
        check("lit_collide_read", 32'(got), 32'h1234);
        do_read(16'd5, 0, 1'b0, got);
        check("lit_collide_unchanged", 32'(got), 32'h1234);

        // Address wrap to the low index bits.
        do_write(16'h0103, 16'hA5A5, 0);
        do_read(16'h0003, 0, 1'b0, got);
        check("lit_wrap", 32'(got), 32'hA5A5);

        // Reset during WRITE_WAIT drops the write.
        do_write(16'd9, 16'h0909, 0);
        @(posedge clk); #1;
        bus.writeM  = 1'b1;
        bus.address = 16'd9;
        tb_drv      = 1'b1;
        tb_data     = 16'h7777;
        @(posedge clk); #1;
        tb_drv = 1'b0;
        check("rstw_state_before", 32'(bus.state), 32'(MEM_WRITE_WAIT));
        reset = 1'b1;
        #1;
        check("rstw_ack", 32'(bus.ackOutput), 32'd0);
        check("rstw_state", 32'(bus.state), 32'(MEM_IDLE));
        bus.writeM = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rstw_still_idle", 32'(bus.state), 32'(MEM_IDLE));
        do_read(16'd9, 0, 1'b0, got);
        check("lit_rstw_old", 32'(got), 32'h0909);

        // Read held for four cycles after inputReady.
        do_read(16'd7, 4, 1'b0, got);
        check("lit_held_read", 32'(got), 32'hBEEF);

        // Boundary addresses.
        do_write(16'd0, 16'h0001, 0);
        do_write(16'd255, 16'h8000, 2);
        do_read(16'd255, 1, 1'b0, got);
        check("lit_top_addr", 32'(got), 32'h8000);
        do_read(16'h0100, 0, 1'b0, got);
        check("lit_wrap_zero", 32'(got), 32'h0001);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_reads: %0d responses never seen", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
